// File: rtl/dmem_pkg.sv
// Shared types, encodings and access-check helpers for the data-memory responder.
package dmem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b011;
  localparam logic [2:0] LD_HU = 3'b100;

  localparam logic [1:0] ST_B = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_W = 2'b10;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  typedef struct packed {
    logic       write;
    logic [2:0] ld_type;
    logic [1:0] st_type;
  } acc_t;

  function automatic logic is_illegal(input acc_t acc);
    return acc.write ? (acc.st_type == 2'b11) : (acc.ld_type > LD_HU);
  endfunction

  function automatic logic is_misaligned(input acc_t acc, input logic [1:0] off);
    logic half, word;
    half = acc.write ? (acc.st_type == ST_H) : (acc.ld_type == LD_H || acc.ld_type == LD_HU);
    word = acc.write ? (acc.st_type == ST_W) : (acc.ld_type == LD_W);
    return (half && off[0]) || (word && off != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]                  st_type,
  input  logic [2:0]                  ld_type,
  input  logic [1:0]                  off,
  input  logic [31:0]                 wdata,
  input  logic [31:0]                 rword,
  output logic [NUM_LANES-1:0]        be,
  output logic [NUM_LANES-1:0][7:0]   wlanes,
  output logic [31:0]                 rdata
);

  logic [NUM_LANES-1:0][7:0] rlanes;
  logic [7:0]                rbyte;
  logic [15:0]               rhalf;

  assign rlanes = rword;
  assign rbyte  = rlanes[off];
  assign rhalf  = off[1] ? rword[31:16] : rword[15:0];

  // Narrow store data is replicated so each enabled lane picks its own slice.
  always_comb begin
    be     = '0;
    wlanes = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      case (st_type)
        ST_B: begin
          be[i]     = (off == i[1:0]);
          wlanes[i] = wdata[7:0];
        end
        ST_H: begin
          be[i]     = (off[1] == i[1]);
          wlanes[i] = wdata[8*(i%2) +: 8];
        end
        ST_W: begin
          be[i]     = 1'b1;
          wlanes[i] = wdata[8*i +: 8];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ld_type)
      LD_B:    rdata = {{24{rbyte[7]}}, rbyte};
      LD_H:    rdata = {{16{rhalf[15]}}, rhalf};
      LD_W:    rdata = rword;
      LD_BU:   rdata = {24'b0, rbyte};
      LD_HU:   rdata = {16'b0, rhalf};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory slave: IDLE -> BUSY (wait states) -> RESP.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_load_type,
  input  logic [1:0]        req_store_type,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int WORDS = 2 ** (ADDR_W - 2);
  localparam int CNT_W = 4;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q;
  acc_t                      acc_q;
  logic [ADDR_W-1:0]         addr_q;
  logic [31:0]               wdata_q;
  logic [NUM_LANES-1:0][7:0] mem [WORDS];

  logic                      accept, last_busy, bad, do_write;
  logic [31:0]               rword, ld_data;
  logic [NUM_LANES-1:0]      be;
  logic [NUM_LANES-1:0][7:0] wlanes;

  assign accept    = (state_q == IDLE) && req_valid && rst;
  assign last_busy = (state_q == BUSY) && (cnt_q == CNT_W'(WAIT_STATES));
  assign bad       = is_illegal(acc_q) || is_misaligned(acc_q, addr_q[1:0]);
  assign do_write  = last_busy && acc_q.write && !bad && rst;
  assign rword     = mem[addr_q[ADDR_W-1:2]];

  always_ff @(posedge clk) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = BUSY;
      BUSY:    if (last_busy) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gating with rst keeps req_ready low for the whole reset window.
  always_comb begin
    req_ready = (state_q == IDLE) && rst;
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cnt_q <= ((state_q == BUSY) && !last_busy) ? cnt_q + 1'b1 : '0;
      if (last_busy) begin
        rsp_err   <= bad;
        rsp_rdata <= (bad || acc_q.write) ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      acc_q   <= '{write: req_write, ld_type: req_load_type, st_type: req_store_type};
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write)
      for (int i = 0; i < NUM_LANES; i++)
        if (be[i]) mem[addr_q[ADDR_W-1:2]][i] <= wlanes[i];
  end

  dmem_lane_align u_align (
    .st_type (acc_q.st_type),
    .ld_type (acc_q.ld_type),
    .off     (addr_q[1:0]),
    .wdata   (wdata_q),
    .rword   (rword),
    .be      (be),
    .wlanes  (wlanes),
    .rdata   (ld_data)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: a zero-wait and a three-wait responder selected by sel.
module tb_dmem_responder;

  logic        clk = 1'b0, rst = 1'b0, sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_load_type = '0;
  logic [1:0]  req_store_type = '0;

  logic        rr0, rr3, rv0, rv3, re0, re3;
  logic [31:0] rd0, rd3;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct packed {logic err; logic [31:0] data;} exp_t;
  exp_t exp_q[$];
  int   n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rr0),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load_type(req_load_type), .req_store_type(req_store_type),
    .rsp_valid(rv0), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd0), .rsp_err(re0)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rr3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_load_type(req_load_type), .req_store_type(req_store_type),
    .rsp_valid(rv3), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd3), .rsp_err(re3)
  );

  assign req_ready = sel ? rr3 : rr0;
  assign rsp_valid = sel ? rv3 : rv0;
  assign rsp_rdata = sel ? rd3 : rd0;
  assign rsp_err   = sel ? re3 : re0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                       input logic [2:0] lt, input logic [1:0] st);
    req_write = wr; req_addr = a; req_wdata = wd;
    req_load_type = lt; req_store_type = st; req_valid = 1'b1;
  endtask

  task automatic xact(input logic wr, input logic [9:0] a, input logic [31:0] wd,
                      input logic [2:0] lt, input logic [1:0] st,
                      input logic [31:0] ed, input logic ee, input int hold);
    int   k;
    exp_t e;
    exp_q.push_back('{err: ee, data: ed});
    @(negedge clk);
    drive(wr, a, wd, lt, st);
    chk("ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (!rsp_valid && k < 40) begin
      chk("ready_busy", 32'(req_ready), 32'd0);
      @(negedge clk);
      k++;
    end
    chk("latency", 32'(k), sel ? 32'd5 : 32'd2);
    e = exp_q.pop_front();
    for (int h = 0; h < hold; h++) begin
      chk("hold_data", rsp_rdata, e.data);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    chk("rdata", rsp_rdata, e.data);
    chk("err", 32'(rsp_err), 32'(e.err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("valid_drop", 32'(rsp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    repeat (3) @(negedge clk);
    chk("rst_ready0", 32'(rr0), 32'd0);
    chk("rst_ready3", 32'(rr3), 32'd0);
    chk("rst_valid", 32'({rv0, rv3}), 32'd0);
    chk("rst_rdata", rd0 | rd3, 32'd0);
    chk("rst_err", 32'({re0, re3}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'({rr0, rr3}), 32'd3);

    // zero wait states: steering, extension, alignment
    xact(1, 10'h010, 32'hDEADBEEF, 3'd0, 2'b10, 32'h0, 0, 0);
    xact(0, 10'h010, 32'h0, 3'b010, 2'd0, 32'hDEADBEEF, 0, 0);
    xact(0, 10'h013, 32'h0, 3'b000, 2'd0, 32'hFFFFFFDE, 0, 0);
    xact(0, 10'h013, 32'h0, 3'b011, 2'd0, 32'h000000DE, 0, 0);
    xact(0, 10'h012, 32'h0, 3'b001, 2'd0, 32'hFFFFDEAD, 0, 0);
    xact(0, 10'h010, 32'h0, 3'b100, 2'd0, 32'h0000BEEF, 0, 0);
    xact(1, 10'h011, 32'h00000055, 3'd0, 2'b00, 32'h0, 0, 0);
    xact(0, 10'h010, 32'h0, 3'b010, 2'd0, 32'hDEAD55EF, 0, 0);
    xact(0, 10'h011, 32'h0, 3'b000, 2'd0, 32'h00000055, 0, 0);
    xact(0, 10'h012, 32'h0, 3'b010, 2'd0, 32'h0, 1, 0);
    xact(0, 10'h011, 32'h0, 3'b001, 2'd0, 32'h0, 1, 0);
    xact(1, 10'h011, 32'h00001234, 3'd0, 2'b01, 32'h0, 1, 0);
    xact(0, 10'h010, 32'h0, 3'b010, 2'd0, 32'hDEAD55EF, 0, 0);
    xact(1, 10'h012, 32'h00007777, 3'd0, 2'b01, 32'h0, 0, 0);
    xact(0, 10'h012, 32'h0, 3'b001, 2'd0, 32'h00007777, 0, 0);
    xact(0, 10'h010, 32'h0, 3'b101, 2'd0, 32'h0, 1, 0);
    xact(1, 10'h010, 32'hFFFFFFFF, 3'd0, 2'b11, 32'h0, 1, 0);
    xact(1, 10'h012, 32'hFFFFFFFF, 3'd0, 2'b10, 32'h0, 1, 0);
    xact(0, 10'h010, 32'h0, 3'b010, 2'd0, 32'h777755EF, 0, 0);

    // three wait states with a stalled consumer
    sel = 1'b1;
    xact(1, 10'h030, 32'hCAFEF00D, 3'd0, 2'b10, 32'h0, 0, 0);
    xact(0, 10'h030, 32'h0, 3'b010, 2'd0, 32'hCAFEF00D, 0, 4);

    // reset while a store is still waiting
    xact(1, 10'h020, 32'hAAAA5555, 3'd0, 2'b10, 32'h0, 0, 0);
    @(negedge clk);
    drive(1, 10'h020, 32'h12345678, 3'd0, 2'b10);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_ready", 32'(req_ready), 32'd1);
    seen = 1'b0;
    repeat (8) begin
      seen |= rsp_valid;
      @(negedge clk);
    end
    chk("dropped_valid", 32'(seen), 32'd0);
    xact(0, 10'h020, 32'h0, 3'b010, 2'd0, 32'hAAAA5555, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
